mybusmatrix5x7_rrarb_s6: RTL and testbench
==========================================

MYBUSMATRIX5X7_RRARB_S6 -- requirements
Module: mybusmatrix5x7_rrarb_S6

Interface
REQ-001 SHALL provide: HCLK  input  1  AHB system clock; all state on rising edge.
REQ-002 SHALL provide: HRESET  input  1  reset, asynchronous, active-high.
REQ-003 SHALL provide: req_port2, req_port3, req_port4  input  1 each  input-port requests for slave S6.
REQ-004 SHALL provide: HREADYM  input  1  slave-side transfer done; qualifies all register updates.
REQ-005 SHALL provide: HSELM  input  1  slave select of current address phase.
REQ-006 SHALL provide: HTRANSM  input  2  transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-007 SHALL provide: HBURSTM  input  3  burst type (000 SINGLE, 001 INCR, 010/011 WRAP4/INCR4, 100/101 WRAP8/INCR8, 110/111 WRAP16/INCR16).
REQ-008 SHALL provide: HMASTLOCKM  input  1  locked transfer.
REQ-009 SHALL provide: addr_in_port  output  3  granted input port, encodings 3'b010/011/100 only after the first grant.
REQ-010 SHALL provide: no_port  output  1  no input port selected.
REQ-011 SHALL provide: burst_hold  output  1  high while beat_cnt != 0.

Function
REQ-012 State SHALL be: addr_in_port (3b), no_port (1b), beat_cnt (4b); all update only on a rising HCLK edge with HREADYM=1.
REQ-013 Counter load SHALL occur when HREADYM & HSELM & ~no_port & HTRANSM=NONSEQ: beat_cnt <= 3 (4-beat), 7 (8-beat), 15 (16-beat), 0 (SINGLE/INCR).
REQ-014 Counter decrement SHALL occur when HREADYM & HSELM & HTRANSM=SEQ & beat_cnt>0: beat_cnt <= beat_cnt-1.
REQ-015 BUSY SHALL leave beat_cnt unchanged.
REQ-016 IDLE with beat_cnt>0 (early termination) SHALL clear beat_cnt to 0.
REQ-017 cnt_next SHALL denote the beat_cnt value the current cycle produces per REQ-013..016.
REQ-018 Next-grant priority, first match wins: (a) HMASTLOCKM=1 -> keep addr_in_port, no_port_next=0.
REQ-019 (b) cnt_next != 0 -> keep addr_in_port, no_port_next=0.
REQ-020 (c) HSELM & HBURSTM=INCR & HTRANSM in {BUSY,SEQ} -> keep, no_port_next=0.
REQ-021 (d) any req asserted -> round-robin pick, starting at the port after addr_in_port in order 2->3->4->2, wrapping to include the current port last; no_port_next=0.
REQ-022 (e) HSELM=1 -> keep, no_port_next=0.
REQ-023 (f) otherwise -> keep addr_in_port, no_port_next=1.
REQ-024 When addr_in_port=3'b000, the round-robin search SHALL start at port 2.
REQ-025 Latency: grant SHALL change one HCLK edge after the deciding cycle with HREADYM=1; HREADYM=0 SHALL freeze all outputs.
REQ-026 Round-robin SHALL guarantee that a continuously asserted request is granted within two competing grants, in the absence of lock.
REQ-027 burst_hold SHALL be registered (beat_cnt != 0), not combinational from inputs.
REQ-028 A NONSEQ arriving while beat_cnt>0 SHALL reload per REQ-013 (new burst replaces old).

Reset
REQ-029 HRESET=1 SHALL immediately force addr_in_port=3'b000, no_port=1, beat_cnt=0, burst_hold=0, independent of HCLK.
REQ-030 Reset asserted mid-burst or mid-lock SHALL discard hold state; after release, arbitration SHALL restart per REQ-024.

Verification
REQ-031 Reset, then req_port3=1 with HREADYM=1 for one edge -> addr_in_port=011, no_port=0.
REQ-032 All three reqs held high, HTRANSM=NONSEQ SINGLE each cycle -> grant sequence 010, 011, 100, 010, ...
REQ-033 Port 3 owns, NONSEQ INCR4 then 3 SEQ with req_port2/4 high -> addr_in_port stays 011 for all 4 beats (burst_hold high for 3 edges), then switches to 100.
REQ-034 INCR8 with one BUSY and HREADYM=0 for two cycles mid-burst -> beat_cnt and grant frozen; burst completes after 7 SEQ accepted.
REQ-035 HMASTLOCKM=1 while port 2 owns and req_port3=1 -> grant stays 010 until HMASTLOCKM=0, then moves to 011.
REQ-036 No reqs, HSELM=0 -> no_port=1 with addr_in_port unchanged; HRESET pulsed mid-INCR16 -> outputs return to 000/1/0 without clock.

Source files
------------

// File: rtl/mybusmatrix5x7_rrarb_s6_if.sv
// Bus-matrix output-stage signals for slave S6: input-port requests, slave-side
// AHB address-phase control, and the resulting grant and burst-hold status.
interface mybusmatrix5x7_rrarb_s6_if;
  logic       req_port2;
  logic       req_port3;
  logic       req_port4;
  logic       HREADYM;
  logic       HSELM;
  logic [1:0] HTRANSM;
  logic [2:0] HBURSTM;
  logic       HMASTLOCKM;
  logic [2:0] addr_in_port;
  logic       no_port;
  logic       burst_hold;

  // Driven by the upstream matrix and slave; observes the grant.
  modport master (
    output req_port2, req_port3, req_port4,
    output HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    input  addr_in_port, no_port, burst_hold
  );

  // The arbiter itself.
  modport slave (
    input  req_port2, req_port3, req_port4,
    input  HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    output addr_in_port, no_port, burst_hold
  );
endinterface

// File: rtl/mybusmatrix5x7_rrarb_s6.sv
// Round-robin arbiter for slave S6 of the 5x7 bus matrix: picks one of input
// ports 2/3/4 and holds the grant across fixed-length bursts and locked transfers.
module mybusmatrix5x7_rrarb_s6 (
  input logic                         HCLK,
  input logic                         HRESET,
  mybusmatrix5x7_rrarb_s6_if.slave    bus
);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransBusy   = 2'b01;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;

  localparam logic [2:0] BurstIncr = 3'b001;

  localparam logic [2:0] Port2  = 3'b010;
  localparam logic [2:0] Port3  = 3'b011;
  localparam logic [2:0] Port4  = 3'b100;
  localparam logic [2:0] PortNo = 3'b000;

  logic [2:0] addr_in_port_q, addr_in_port_d;
  logic       no_port_q, no_port_d;
  logic [3:0] beat_cnt_q, cnt_next;
  logic       burst_hold_q;

  logic       any_req;
  logic [2:0] rr_pick;
  logic       incr_cont;

  // Remaining beats after the NONSEQ beat; undefined-length bursts carry no count.
  function automatic logic [3:0] burst_remaining(input logic [2:0] hburst);
    unique case (hburst[2:1])
      2'b01:   burst_remaining = 4'd3;
      2'b10:   burst_remaining = 4'd7;
      2'b11:   burst_remaining = 4'd15;
      default: burst_remaining = 4'd0;
    endcase
  endfunction

  always_comb begin
    cnt_next = beat_cnt_q;
    if (bus.HSELM && !no_port_q && bus.HTRANSM == TransNonseq) begin
      cnt_next = burst_remaining(bus.HBURSTM);
    end else if (bus.HSELM && bus.HTRANSM == TransSeq && beat_cnt_q != 4'd0) begin
      cnt_next = beat_cnt_q - 4'd1;
    end else if (bus.HTRANSM == TransIdle && beat_cnt_q != 4'd0) begin
      // Early termination of a fixed-length burst.
      cnt_next = 4'd0;
    end
  end

  assign any_req   = bus.req_port2 | bus.req_port3 | bus.req_port4;
  assign incr_cont = bus.HSELM && bus.HBURSTM == BurstIncr &&
                     (bus.HTRANSM == TransBusy || bus.HTRANSM == TransSeq);

  // Search starts after the current owner; the owner itself is considered last.
  always_comb begin
    rr_pick = addr_in_port_q;
    unique case (addr_in_port_q)
      Port2: begin
        if (bus.req_port3)      rr_pick = Port3;
        else if (bus.req_port4) rr_pick = Port4;
        else if (bus.req_port2) rr_pick = Port2;
      end
      Port3: begin
        if (bus.req_port4)      rr_pick = Port4;
        else if (bus.req_port2) rr_pick = Port2;
        else if (bus.req_port3) rr_pick = Port3;
      end
      default: begin
        if (bus.req_port2)      rr_pick = Port2;
        else if (bus.req_port3) rr_pick = Port3;
        else if (bus.req_port4) rr_pick = Port4;
      end
    endcase
  end

  always_comb begin
    addr_in_port_d = addr_in_port_q;
    no_port_d      = 1'b0;
    if (bus.HMASTLOCKM) begin
      no_port_d = 1'b0;
    end else if (cnt_next != 4'd0) begin
      no_port_d = 1'b0;
    end else if (incr_cont) begin
      no_port_d = 1'b0;
    end else if (any_req) begin
      addr_in_port_d = rr_pick;
    end else if (bus.HSELM) begin
      no_port_d = 1'b0;
    end else begin
      no_port_d = 1'b1;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr_in_port_q <= PortNo;
      no_port_q      <= 1'b1;
      beat_cnt_q     <= 4'd0;
      burst_hold_q   <= 1'b0;
    end else if (bus.HREADYM) begin
      addr_in_port_q <= addr_in_port_d;
      no_port_q      <= no_port_d;
      beat_cnt_q     <= cnt_next;
      burst_hold_q   <= (cnt_next != 4'd0);
    end
  end

  assign bus.addr_in_port = addr_in_port_q;
  assign bus.no_port      = no_port_q;
  assign bus.burst_hold   = burst_hold_q;

endmodule

// File: tb/tb_mybusmatrix5x7_rrarb_s6.sv
// Randomised and directed check of the S6 round-robin arbiter against a
// behavioural model of the grant, burst counter and hold rules.
module tb_mybusmatrix5x7_rrarb_s6;

  logic HCLK;
  logic HRESET;

  mybusmatrix5x7_rrarb_s6_if bus ();

  mybusmatrix5x7_rrarb_s6 dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_checks;
  int n_errors;

  // Model state: grant as a port number (0 = none yet), flag, beats remaining.
  int m_grant;
  int m_np;
  int m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_grant = 0;
    m_np    = 1;
    m_cnt   = 0;
  endtask

  task automatic model_edge();
    int nc;
    int reqs[3];
    int start;
    int p;
    bit found;
    if (!bus.HREADYM) return;
    nc = m_cnt;
    if (bus.HSELM && m_np == 0 && bus.HTRANSM == 2'b10) begin
      if (bus.HBURSTM < 3'd2) nc = 0;
      else nc = (4 << (int'(bus.HBURSTM) / 2 - 1)) - 1;
    end else if (bus.HSELM && bus.HTRANSM == 2'b11 && m_cnt > 0) begin
      nc = m_cnt - 1;
    end else if (bus.HTRANSM == 2'b00 && m_cnt > 0) begin
      nc = 0;
    end
    reqs[0] = int'(bus.req_port2);
    reqs[1] = int'(bus.req_port3);
    reqs[2] = int'(bus.req_port4);
    if (bus.HMASTLOCKM || nc != 0 ||
        (bus.HSELM && bus.HBURSTM == 3'b001 && bus.HTRANSM[0])) begin
      m_np = 0;
    end else if (reqs[0] + reqs[1] + reqs[2] > 0) begin
      start = (m_grant == 0) ? 0 : (m_grant - 2 + 1) % 3;
      found = 0;
      for (int k = 0; k < 3; k++) begin
        p = (start + k) % 3;
        if (!found && reqs[p] != 0) begin
          m_grant = p + 2;
          found = 1;
        end
      end
      m_np = 0;
    end else begin
      m_np = bus.HSELM ? 0 : 1;
    end
    m_cnt = nc;
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, ".grant"}, 32'(bus.addr_in_port), m_grant);
    check_eq({tag, ".no_port"}, 32'(bus.no_port), m_np);
    check_eq({tag, ".hold"}, 32'(bus.burst_hold), (m_cnt != 0) ? 1 : 0);
  endtask

  task automatic step(input string tag);
    @(posedge HCLK);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic drive(input logic [2:0] reqs, input logic ready, input logic sel,
                       input logic [1:0] trans, input logic [2:0] burst, input logic lock);
    bus.req_port2  = reqs[0];
    bus.req_port3  = reqs[1];
    bus.req_port4  = reqs[2];
    bus.HREADYM    = ready;
    bus.HSELM      = sel;
    bus.HTRANSM    = trans;
    bus.HBURSTM    = burst;
    bus.HMASTLOCKM = lock;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    drive(3'b000, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0);
    HRESET = 1'b1;
    model_reset();
    #1;
    check_model("reset");
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;

    // Single requester on port 3.
    drive(3'b010, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0);
    step("single");
    check_eq("single.port3", 32'(bus.addr_in_port), 32'd3);

    // All requesting, back-to-back SINGLE transfers rotate the grant.
    drive(3'b111, 1'b1, 1'b1, 2'b10, 3'b000, 1'b0);
    step("rr1");
    check_eq("rr1.port4", 32'(bus.addr_in_port), 32'd4);
    step("rr2");
    check_eq("rr2.port2", 32'(bus.addr_in_port), 32'd2);
    step("rr3");
    check_eq("rr3.port3", 32'(bus.addr_in_port), 32'd3);

    // INCR4 on port 3 holds the grant for the whole burst.
    drive(3'b101, 1'b1, 1'b1, 2'b10, 3'b011, 1'b0);
    step("incr4.ns");
    check_eq("incr4.ns.hold", 32'(bus.burst_hold), 32'd1);
    bus.HTRANSM = 2'b11;
    step("incr4.s1");
    step("incr4.s2");
    check_eq("incr4.s2.port3", 32'(bus.addr_in_port), 32'd3);
    step("incr4.s3");
    check_eq("incr4.s3.port4", 32'(bus.addr_in_port), 32'd4);
    check_eq("incr4.s3.hold", 32'(bus.burst_hold), 32'd0);

    // INCR8 with a BUSY beat and two wait states.
    drive(3'b011, 1'b1, 1'b1, 2'b10, 3'b101, 1'b0);
    step("incr8.ns");
    bus.HTRANSM = 2'b11;
    step("incr8.s1");
    bus.HTRANSM = 2'b01;
    step("incr8.busy");
    bus.HTRANSM = 2'b11;
    bus.HREADYM = 1'b0;
    step("incr8.wait1");
    step("incr8.wait2");
    check_eq("incr8.frozen", 32'(bus.addr_in_port), 32'd4);
    bus.HREADYM = 1'b1;
    for (int i = 0; i < 6; i++) step("incr8.seq");
    check_eq("incr8.done.hold", 32'(bus.burst_hold), 32'd0);

    // Lock keeps port 2 despite a competing request.
    drive(3'b001, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0);
    step("lock.own");
    drive(3'b010, 1'b1, 1'b1, 2'b10, 3'b000, 1'b1);
    for (int i = 0; i < 3; i++) step("lock.hold");
    check_eq("lock.port2", 32'(bus.addr_in_port), 32'd2);
    bus.HMASTLOCKM = 1'b0;
    step("lock.rel");
    check_eq("lock.port3", 32'(bus.addr_in_port), 32'd3);

    // Idle slave with no requests.
    drive(3'b000, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0);
    step("idle");
    check_eq("idle.no_port", 32'(bus.no_port), 32'd1);
    check_eq("idle.keep", 32'(bus.addr_in_port), 32'd3);

    // Asynchronous reset in the middle of an INCR16.
    drive(3'b000, 1'b1, 1'b1, 2'b00, 3'b000, 1'b0);
    step("incr16.sel");
    drive(3'b100, 1'b1, 1'b1, 2'b10, 3'b111, 1'b0);
    step("incr16.ns");
    bus.HTRANSM = 2'b11;
    step("incr16.s1");
    step("incr16.s2");
    #2;
    HRESET = 1'b1;
    model_reset();
    #1;
    check_model("async_rst");
    #3;
    HRESET = 1'b0;

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      drive(3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0));
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
